alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-issue and result-capture stage wrapped around the 16-bit combinational ALU.
//  Buffers operation commands, drives registered operands and opcode into the ALU, and captures ALU_OUT.
//  Derives C/V/N/Z flags and keeps an accumulator so chained operations need no host round-trip.
//  Valid/ready on both command and result sides; sits between the command source and the register/writeback logic.
// PARAMETERS
//  WIDTH  16  datapath width; must match the ALU operand width
//  DEPTH  4   command FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      command FIFO not full
//  cmd_sel    in   3      opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL1 A, 111 SHR1 A
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  cmd_acc_a  in   1      1: use accumulator as A; cmd_a is ignored
//  alu_a      out  WIDTH  registered operand A to the ALU
//  alu_b      out  WIDTH  registered operand B to the ALU
//  alu_sel    out  3      registered opcode to the ALU
//  alu_out    in   WIDTH  ALU result (combinational from alu_a, alu_b, alu_sel)
//  res_valid  out  1      result available
//  res_ready  in   1      result consumer ready
//  res_data   out  WIDTH  captured result
//  res_flags  out  4      {C,V,N,Z}
//  acc_q      out  WIDTH  accumulator, equals the last captured result
//  busy       out  1      state != IDLE or FIFO not empty
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge):
//   - FIFO emptied; state := IDLE; in-flight and queued commands dropped.
//   - All outputs 0 except cmd_ready=1.
//   - rst overrides every other input in the same cycle.
//  Command side:
//   - Push when cmd_valid && cmd_ready.
//   - cmd_ready = !full. A push while full is refused even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle are both legal when not full.
//  FSM: IDLE, EXEC, HOLD.
//   - IDLE: if FIFO not empty, pop and load alu_a (acc_q if cmd_acc_a), alu_b and alu_sel; go to EXEC.
//     No bypass: a command pushed into an empty FIFO is popped the next cycle.
//   - EXEC: at the edge, capture alu_out into res_data and acc_q, register flags, set res_valid=1; go to HOLD.
//   - HOLD: res_data and res_flags held stable while !res_ready.
//     On res_valid && res_ready: res_valid:=0. Then pop the next command and go to EXEC if FIFO not empty, else go to IDLE.
//  Latency and throughput:
//   - Command handshake at edge k gives res_valid=1 after edge k+2 when the stage is idle.
//   - Peak throughput is 1 result per 2 cycles.
//   - Results leave in command order.
//  Accumulator dependency: acc_q is updated in EXEC before any later pop, so back-to-back cmd_acc_a commands see the prior result.
//  Flags, computed in EXEC from the registered operands; all arithmetic is WIDTH bits, modulo 2^WIDTH:
//   - Z = (alu_out == 0); N = alu_out[WIDTH-1].
//   - ADD: C = carry-out of the WIDTH+1-bit sum; V = signed overflow.
//   - SUB: C = borrow (alu_a < alu_b, unsigned); V = signed overflow.
//   - SHL: C = alu_a[WIDTH-1]. SHR: C = alu_a[0]. Both: V=0.
//   - AND, OR, XOR, NOT: C=0, V=0.
//  alu_* outputs hold their last value outside EXEC.
// STRUCTURE
//  alu_pkg:
//   - opcode localparams OP_ADD..OP_SHR;
//   - flag bit indices FLAG_C=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0;
//   - state typedef seq_state_t {IDLE, EXEC, HOLD}.
//  Sub-module alu_cmd_fifo:
//   - synchronous FIFO, WIDTH*2+4 bits wide, DEPTH deep;
//   - full/empty taken from pointers with an extra wrap bit.
//  The ALU itself is instantiated by the parent, not inside this block.
// TESTING
//  1. rst held 2 cycles -> res_valid=0, cmd_ready=1, acc_q=0, busy=0; a command pushed during rst is not executed.
//  2. ADD a=FFFF b=0001, res_ready=1 -> res_valid after handshake+2; res_data=0000, flags C=1 V=0 N=0 Z=1.
//  3. SUB a=8000 b=0001 -> 7FFF, C=0 V=1 N=0 Z=0. Then SHL a=8001 -> 0002, C=1.
//  4. ADD 0005+0003, then ADD cmd_acc_a=1 b=0002, then SUB cmd_acc_a=1 b=000A -> results 0008, 000A, 0000 (Z=1); acc_q=0000.
//  5. res_ready=0, push 6 commands -> 5 accepted, cmd_ready=0 on the 6th; res_data stable.
//     Then res_ready=1 -> all 5 results in order, one per 2 cycles.
//  6. rst asserted in EXEC with 3 queued -> next cycle res_valid=0, FIFO empty, and no further results appear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and sequencer state encoding for the ALU
// command-issue / result-capture stage.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from read/write pointers that
// carry one extra wrap bit.
module alu_cmd_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              do_push_s;
  logic              do_pop_s;

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (!rst && do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered commands to an external combinational ALU, captures its
// result with C/V/N/Z flags and keeps an accumulator for chained operations.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_acc_a,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  output logic [WIDTH-1:0] acc_q,
  output logic             busy
);

  localparam int ENTRY_W = 2 * WIDTH + 4;

  seq_state_t         state_r;
  logic [WIDTH-1:0]   alu_a_r, alu_b_r, res_data_r, acc_r;
  logic [2:0]         alu_sel_r;
  logic               res_valid_r;
  logic [3:0]         flags_r, flags_s;
  logic               fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [ENTRY_W-1:0] push_data_s, pop_data_s;
  logic [WIDTH-1:0]   pop_a_s, pop_b_s;
  logic [2:0]         pop_sel_s;
  logic               pop_acc_s;
  logic [WIDTH:0]     sum_s;
  logic               carry_s, ovf_s;

  assign push_s      = cmd_valid && !fifo_full_s;
  assign push_data_s = {cmd_acc_a, cmd_sel, cmd_a, cmd_b};
  assign {pop_acc_s, pop_sel_s, pop_a_s, pop_b_s} = pop_data_s;
  assign pop_s = !fifo_empty_s &&
                 ((state_r == IDLE) || ((state_r == HOLD) && res_valid_r && res_ready));

  alu_cmd_fifo #(.DATA_W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Flags derive from the registered operands, so they match what the ALU saw.
  always_comb begin
    sum_s   = {1'b0, alu_a_r} + {1'b0, alu_b_r};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (alu_sel_r)
      OP_ADD: begin
        carry_s = sum_s[WIDTH];
        ovf_s   = (alu_a_r[WIDTH-1] == alu_b_r[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a_r[WIDTH-1]);
      end
      OP_SUB: begin
        carry_s = (alu_a_r < alu_b_r);
        ovf_s   = (alu_a_r[WIDTH-1] != alu_b_r[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a_r[WIDTH-1]);
      end
      OP_SHL:  carry_s = alu_a_r[WIDTH-1];
      OP_SHR:  carry_s = alu_a_r[0];
      default: carry_s = 1'b0;
    endcase
    flags_s         = 4'b0000;
    flags_s[FLAG_C] = carry_s;
    flags_s[FLAG_V] = ovf_s;
    flags_s[FLAG_N] = alu_out[WIDTH-1];
    flags_s[FLAG_Z] = (alu_out == {WIDTH{1'b0}});
  end

  // Issue / capture / hand-off sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_sel_r   <= 3'b000;
      res_data_r  <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      res_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            alu_a_r   <= pop_acc_s ? acc_r : pop_a_s;
            alu_b_r   <= pop_b_s;
            alu_sel_r <= pop_sel_s;
            state_r   <= EXEC;
          end
        end
        EXEC: begin
          res_data_r  <= alu_out;
          acc_r       <= alu_out;
          flags_r     <= flags_s;
          res_valid_r <= 1'b1;
          state_r     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            if (pop_s) begin
              alu_a_r   <= pop_acc_s ? acc_r : pop_a_s;
              alu_b_r   <= pop_b_s;
              alu_sel_r <= pop_sel_s;
              state_r   <= EXEC;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign cmd_ready = !fifo_full_s;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_sel   = alu_sel_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_flags = flags_r;
  assign acc_q     = acc_r;
  assign busy      = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit ALU attached
// to the alu_* interface and hand-computed expected results.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_sel;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_acc_a;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_flags;
  logic [15:0] acc_q;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int waited;

  alu_op_sequencer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc_a(cmd_acc_a),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .acc_q(acc_q), .busy(busy)
  );

  // Behavioural ALU driven by the sequencer's registered operands
  always_comb begin
    case (alu_sel)
      3'd0:    alu_out = alu_a + alu_b;
      3'd1:    alu_out = alu_a - alu_b;
      3'd2:    alu_out = alu_a & alu_b;
      3'd3:    alu_out = alu_a | alu_b;
      3'd4:    alu_out = alu_a ^ alu_b;
      3'd5:    alu_out = ~alu_a;
      3'd6:    alu_out = alu_a << 1;
      default: alu_out = alu_a >> 1;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                      input logic acc);
    int n;
    cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_acc_a = acc; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for a result, checks it, then consumes it (res_ready must be 1).
  task automatic get_res(input string tag, input logic [15:0] exp_d, input logic [3:0] exp_f,
                         output int wcyc);
    wcyc = 0;
    while (!res_valid && wcyc < 30) begin
      step();
      wcyc++;
    end
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_data"}, res_data, exp_d);
    chk({tag, "_flags"}, res_flags, exp_f);
    step();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 16'h0001; cmd_b = 16'h0001;
    cmd_acc_a = 1'b0; res_ready = 1'b1;

    // 1: reset with a command offered throughout
    step(); step();
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_acc_q", acc_q, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_data", res_data, 16'h0000);
    repeat (4) step();
    chk("rst_no_exec_valid", res_valid, 1'b0);
    chk("rst_no_exec_busy", busy, 1'b0);

    // 2: ADD FFFF+0001, latency handshake+2
    send(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    get_res("add_wrap", 16'h0000, 4'b1001, waited);
    chk("add_latency", waited, 2);

    // 3: SUB overflow, then SHL carry-out
    send(3'd1, 16'h8000, 16'h0001, 1'b0);
    get_res("sub_ovf", 16'h7FFF, 4'b0100, waited);
    send(3'd6, 16'h8001, 16'h0000, 1'b0);
    get_res("shl_carry", 16'h0002, 4'b1000, waited);
    chk("shl_acc_q", acc_q, 16'h0002);

    // 4: accumulator chaining, sent back-to-back
    fork
      begin
        send(3'd0, 16'h0005, 16'h0003, 1'b0);
        send(3'd0, 16'h1234, 16'h0002, 1'b1);
        send(3'd1, 16'hFFFF, 16'h000A, 1'b1);
      end
      begin
        int w;
        get_res("chain0", 16'h0008, 4'b0000, w);
        get_res("chain1", 16'h000A, 4'b0000, w);
        get_res("chain2", 16'h0000, 4'b0001, w);
      end
    join
    chk("chain_acc_q", acc_q, 16'h0000);

    // 5: backpressure fills stage + FIFO; sixth command refused
    res_ready = 1'b0;
    begin
      logic [2:0]  sel_t [6];
      logic [15:0] a_t   [6];
      logic [15:0] b_t   [6];
      logic [15:0] d_t   [5];
      logic [3:0]  f_t   [5];
      logic        rdy_t [6];
      sel_t = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
      a_t   = '{16'hF0F0, 16'h0F00, 16'hAAAA, 16'h00FF, 16'h0003, 16'h0001};
      b_t   = '{16'hFF00, 16'h00F0, 16'hAAAA, 16'h0000, 16'h0000, 16'h0001};
      d_t   = '{16'hF000, 16'h0FF0, 16'h0000, 16'hFF00, 16'h0001};
      f_t   = '{4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b1000};
      rdy_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
        cmd_sel = sel_t[i]; cmd_a = a_t[i]; cmd_b = b_t[i]; cmd_acc_a = 1'b0;
        cmd_valid = 1'b1;
        chk($sformatf("bp_ready%0d", i), cmd_ready, rdy_t[i]);
        step();
      end
      chk("bp_ready_still_full", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_hold_data%0d", i), res_data, 16'hF000);
        step();
      end
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        get_res($sformatf("bp_res%0d", i), d_t[i], f_t[i], waited);
        if (i > 0) chk($sformatf("bp_gap%0d", i), waited, 1);
      end
      repeat (4) step();
      chk("bp_no_sixth", res_valid, 1'b0);
      chk("bp_idle_busy", busy, 1'b0);
    end

    // 6: reset while executing with three commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'd0, 16'h0010, 16'(i), 1'b0);
    res_ready = 1'b1;
    step();
    chk("mid_exec_valid", res_valid, 1'b0);
    chk("mid_exec_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_exec_valid", res_valid, 1'b0);
    chk("rst_exec_busy", busy, 1'b0);
    chk("rst_exec_ready", cmd_ready, 1'b1);
    chk("rst_exec_acc", acc_q, 16'h0000);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (res_valid) seen++;
      end
      chk("rst_exec_no_results", seen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
